// File: rtl/booth_controller.sv
// booth_controller
//   Sequencing FSM for a radix-2 Booth multiplier. Accepts an operand pair,
//   drives the datapath through 16 add/sub + arithmetic-shift steps, and
//   presents the finished product downstream with a valid/ready handshake.
//   The step counter is owned here. An external comparator turns it into the
//   registered terminal flag `comp`, which is asserted when count reaches 14.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   src_valid   operands present on the datapath inputs
//   src_ready   controller can accept operands (high only in IDLE)
//   q_bits      {Q[0], Q[-1]} from the datapath multiplier register
//   comp        registered terminal-count flag from the comparator
//   count       step counter, to the comparator
//   load_en     datapath loads operands and clears A and Q[-1]
//   alu_op      00 NOP, 01 ADD multiplicand, 10 SUB multiplicand
//   shift_en    arithmetic right shift of {A, Q, Q[-1]} this cycle
//   busy        high in RUN and DONE
//   dest_valid  product valid on the datapath outputs
//   dest_ready  downstream accepts the product
module booth_controller #(
  parameter int Width = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [1:0]       q_bits,
  input  logic             comp,
  output logic [Width-1:0] count,
  output logic             load_en,
  output logic [1:0]       alu_op,
  output logic             shift_en,
  output logic             busy,
  output logic             dest_valid,
  input  logic             dest_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;

  // Booth recoding of {Q[0], Q[-1]}: 01 adds, 10 subtracts, 00/11 do nothing,
  // so 11 can never reach alu_op.
  function automatic logic [1:0] booth_op(input logic [1:0] qb);
    logic [1:0] op;
    op = 2'b00;
    if (qb == 2'b01) op = 2'b01;
    else if (qb == 2'b10) op = 2'b10;
    return op;
  endfunction

  // State and step counter: the only registers in the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (src_valid) state <= RUN;
        end
        RUN: begin
          // comp is registered off count==14, so it is high during the
          // count==15 step: that step is the last of 16.
          if (comp) begin
            state <= DONE;
            count <= '0;
          end else begin
            count <= count + Width'(1);
          end
        end
        DONE: begin
          count <= '0;
          if (dest_ready) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Output decode of the current state and inputs.
  always_comb begin
    src_ready  = 1'b0;
    load_en    = 1'b0;
    alu_op     = 2'b00;
    shift_en   = 1'b0;
    busy       = 1'b0;
    dest_valid = 1'b0;
    case (state)
      IDLE: begin
        src_ready = 1'b1;
        load_en   = src_valid;
      end
      RUN: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        alu_op   = booth_op(q_bits);
      end
      DONE: begin
        busy       = 1'b1;
        dest_valid = 1'b1;
      end
      default: begin
        src_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller
//   Bench for booth_controller with a behavioural step comparator
//   (registered flag, set when count == 14). Directed sequences drive the
//   handshakes; a monitor pushes the expected run length and latency for every
//   accepted operand pair and pops them when the product becomes valid.
module tb_booth_controller;

  localparam int Width = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             src_valid;
  logic             src_ready;
  logic [1:0]       q_bits;
  logic             comp;
  logic [Width-1:0] count;
  logic             load_en;
  logic [1:0]       alu_op;
  logic             shift_en;
  logic             busy;
  logic             dest_valid;
  logic             dest_ready;

  logic comp_r;
  logic comp_force;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // scoreboard state
  int exp_sh[$];
  int exp_lat[$];
  int acc_log[$];
  int shifts  = 0;
  int acc_cyc = 0;
  logic dv_q  = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // comparator model: registered terminal-count flag
  always @(posedge clk or negedge reset) begin
    if (!reset) comp_r <= 1'b0;
    else        comp_r <= (count == Width'(14));
  end
  assign comp = comp_r | comp_force;

  booth_controller #(.Width(Width)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .q_bits     (q_bits),
    .comp       (comp),
    .count      (count),
    .load_en    (load_en),
    .alu_op     (alu_op),
    .shift_en   (shift_en),
    .busy       (busy),
    .dest_valid (dest_valid),
    .dest_ready (dest_ready)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      exp_sh.delete();
      exp_lat.delete();
      shifts = 0;
      dv_q   = 1'b0;
    end else begin
      if (alu_op == 2'b11) chk("alu_op_11", int'(alu_op), 0);
      if (shift_en) shifts++;
      if (dest_valid && !dv_q) begin
        if (exp_sh.size() == 0) chk("sb_unexpected_valid", 1, 0);
        else begin
          chk("sb_shift_pulses", shifts, exp_sh.pop_front());
          chk("sb_latency", cyc - acc_cyc, exp_lat.pop_front());
        end
      end
      dv_q = dest_valid;
      if (src_valid && src_ready) begin
        exp_sh.push_back(16);
        exp_lat.push_back(17);
        acc_log.push_back(cyc);
        acc_cyc = cyc;
        shifts  = 0;
      end
    end
  end

  task automatic accept_op();
    @(posedge clk); #1 src_valid = 1'b1;
    @(posedge clk); #1 src_valid = 1'b0;
  endtask

  task automatic wait_dv(input int max_cyc);
    int n;
    n = 0;
    while (!dest_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!dest_valid) chk("timeout_dest_valid", 0, 1);
  endtask

  task automatic drain();
    @(posedge clk); #1 dest_ready = 1'b1;
    @(posedge clk); #1 dest_ready = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_src_ready"}, int'(src_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_shift_en"}, int'(shift_en), 0);
    chk({tag, "_load_en"}, int'(load_en), 0);
    chk({tag, "_alu_op"}, int'(alu_op), 0);
    chk({tag, "_dest_valid"}, int'(dest_valid), 0);
  endtask

  initial begin
    reset      = 1'b0;
    src_valid  = 1'b0;
    q_bits     = 2'b00;
    dest_ready = 1'b0;
    comp_force = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk_idle("reset");
    #2 reset = 1'b1;

    // single operation, q_bits held 00
    @(posedge clk); #1 src_valid = 1'b1;
    @(negedge clk);
    chk("accept_load_en", int'(load_en), 1);
    chk("accept_src_ready", int'(src_ready), 1);
    @(posedge clk); #1 src_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("run_shift_en", int'(shift_en), 1);
      chk("run_count", int'(count), i);
      chk("run_alu_op", int'(alu_op), 0);
      chk("run_dest_valid", int'(dest_valid), 0);
    end
    // DONE, dest_ready low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("done_dest_valid", int'(dest_valid), 1);
      chk("done_src_ready", int'(src_ready), 0);
      chk("done_shift_en", int'(shift_en), 0);
      chk("done_count", int'(count), 0);
    end
    @(posedge clk); #1 dest_ready = 1'b1;
    @(negedge clk);
    chk("done_hold_until_edge", int'(dest_valid), 1);
    @(posedge clk); #1 dest_ready = 1'b0;
    @(negedge clk);
    chk_idle("after_done");

    // q_bits recoding, plus spurious src_valid during RUN
    accept_op();
    q_bits = 2'b01; @(negedge clk); chk("booth_01", int'(alu_op), 1);
    @(posedge clk); #1 q_bits = 2'b10; @(negedge clk); chk("booth_10", int'(alu_op), 2);
    @(posedge clk); #1 q_bits = 2'b11; @(negedge clk); chk("booth_11", int'(alu_op), 0);
    @(posedge clk); #1 q_bits = 2'b00; @(negedge clk); chk("booth_00", int'(alu_op), 0);
    repeat (2) @(posedge clk);
    #1 src_valid = 1'b1;
    @(negedge clk);
    chk("spurious_sv_load_en", int'(load_en), 0);
    chk("spurious_sv_src_ready", int'(src_ready), 0);
    chk("spurious_sv_busy", int'(busy), 1);
    @(posedge clk); #1 src_valid = 1'b0;
    wait_dv(30);
    drain();

    // spurious comp pulse in IDLE
    @(posedge clk); #1 comp_force = 1'b1;
    @(negedge clk);
    chk("spurious_comp_src_ready", int'(src_ready), 1);
    @(posedge clk); #1 comp_force = 1'b0;
    @(negedge clk);
    chk_idle("spurious_comp");
    accept_op();
    wait_dv(30);
    drain();

    // asynchronous reset mid-run at count 7
    accept_op();
    repeat (8) @(negedge clk);
    chk("midrun_count", int'(count), 7);
    #2 reset = 1'b0;
    #1 chk_idle("midrun_reset");
    repeat (3) @(negedge clk);
    chk_idle("midrun_reset_hold");
    #2 reset = 1'b1;
    accept_op();
    wait_dv(30);
    drain();

    // back-to-back with src_valid and dest_ready held high
    @(negedge clk);
    acc_log.delete();
    @(posedge clk); #1 src_valid = 1'b1; dest_ready = 1'b1;
    repeat (60) @(posedge clk);
    #1 src_valid = 1'b0;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (busy) chk("timeout_b2b_idle", 1, 0);
    end
    dest_ready = 1'b0;
    chk("b2b_accepts", (acc_log.size() >= 3) ? 1 : 0, 1);
    for (int i = 1; i < acc_log.size(); i++)
      chk("b2b_period", acc_log[i] - acc_log[i-1], 18);

    repeat (2) @(negedge clk);
    chk("sb_drained", exp_sh.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/booth_controller.md
Name: booth_controller

Overview:
- Sequencing FSM for the radix-2 Booth multiplier.
- Accepts an operand-pair handshake, drives the datapath (load, add/sub select, arithmetic shift), and owns the step counter.
- Its `count` output feeds the step comparator; the comparator's registered `comp` flag, asserted when count reaches 14, comes back here to terminate the run after exactly 16 steps.
- Presents the finished product downstream via a valid/ready handshake.

Parameters:
- Width, 5, step-counter width; must match the comparator. The terminal compare value is fixed at 14 inside the comparator.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- src_valid  input  1  operands present on the datapath inputs
- src_ready  output  1  controller can accept operands
- q_bits  input  2  {Q[0], Q[-1]} from the datapath multiplier register
- comp  input  1  registered terminal-count flag from the comparator
- count  output  Width  step counter, to the comparator
- load_en  output  1  datapath loads operands and clears A and Q[-1]
- alu_op  output  2  00 = NOP, 01 = ADD multiplicand, 10 = SUB multiplicand, 11 never driven
- shift_en  output  1  arithmetic right shift of {A, Q, Q[-1]} this cycle
- busy  output  1  high in RUN and DONE
- dest_valid  output  1  product valid on the datapath outputs
- dest_ready  input  1  downstream accepts the product

Behaviour:
- One clock domain, `clk`; `reset` is asynchronous, active-low.
- Reset asserted, including mid-operation:
  - state = IDLE, count = 0.
  - load_en, alu_op, shift_en, busy and dest_valid all 0.
  - src_ready = 1, since it reflects IDLE.
  - Any partial product is abandoned.
- State encoding: IDLE, RUN, DONE. Outputs are combinational decodes of state and inputs; state and count are the only registers.
- IDLE:
  - src_ready = 1.
  - If src_valid: load_en = 1; count <= 0 at the edge; next state RUN.
  - Otherwise remain in IDLE; count holds 0.
- RUN:
  - shift_en = 1.
  - alu_op is decoded from q_bits in the same cycle: 01 -> ADD, 10 -> SUB, 00 or 11 -> NOP.
  - count <= count + 1 at each edge.
  - If comp = 1: this cycle is the final step. Next state DONE; count <= 0 (no increment).
- Latency:
  - Operands are accepted at edge k.
  - RUN occupies cycles k+1 to k+16, with count 0 to 15. The comparator sees 14 during cycle k+15, so comp = 1 in cycle k+16.
  - dest_valid rises in cycle k+17.
  - Exactly 16 shift_en pulses per multiplication.
- DONE:
  - dest_valid = 1, held stable until dest_ready.
  - src_ready = 0.
  - count holds 0.
  - When dest_ready = 1: next state IDLE.
  - The next operand pair is accepted no earlier than the first IDLE cycle (no DONE-to-RUN bypass).
- dest_ready high before DONE is ignored; dest_valid never depends combinationally on dest_ready.
- src_valid outside IDLE is ignored; the operands are not captured.
- comp = 1 seen in IDLE or DONE is ignored. It can only be stale there, and it must not alter state.
- count never exceeds 15 and never wraps through 31. If comp is stuck at 0, the counter wraps 31 -> 0 and RUN continues; this is a comparator fault and is not guarded here.
- alu_op = 11 must never appear, in any state.

Test Plan:
- Reset: hold reset = 0 for 3 cycles, including one mid-run at count = 7 -> count = 0, IDLE, src_ready = 1, all other outputs 0; the next src_valid starts a fresh 16-step run.
- Single op with comparator model, q_bits held 00, accept at cycle 0 -> shift_en high in cycles 1–16, alu_op = 00 throughout, count runs 0..15, dest_valid rises in cycle 17.
- q_bits sequence 01, 10, 11, 00 in the first four RUN cycles -> alu_op = 01, 10, 00, 00 in those same cycles.
- DONE with dest_ready held low for 5 cycles -> dest_valid stays 1 and src_ready stays 0 throughout; dest_ready = 1 -> IDLE on the next edge.
- Back-to-back: src_valid held high and dest_ready held high -> second accept occurs in the first IDLE cycle after DONE; 18-cycle period per operation.
- Spurious inputs: comp pulsed while in IDLE, and src_valid pulsed during RUN -> no state change, run length still 16.
